yutorina_bus_arbiter: RTL and testbench

//  Round-robin arbiter for the shared external bus used by the CPU mem-stage bus interface,
//  the IF-stage fetch port and DMA/debug masters. Grants one master at a time and holds the

---
 rtl/yutorina_bus_arbiter_pkg.sv | 11 +
 rtl/yutorina_rr_picker.sv | 31 +++
 rtl/yutorina_bus_arbiter.sv | 94 +++++++++
 tb/tb_yutorina_bus_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/yutorina_bus_arbiter_pkg.sv
// yutorina_bus_arbiter_pkg: shared bus constants, master indices and arbiter state type
package yutorina_bus_arbiter_pkg;
    localparam int BUS_MASTER_CNT    = 4;
    localparam int BUS_OWNER_W       = $clog2(BUS_MASTER_CNT);
    localparam int BUS_MAX_HOLD      = 64;
    localparam int BUS_OWNER_CPU_MEM = 0;
    localparam int BUS_OWNER_CPU_IF  = 1;
    localparam int BUS_OWNER_DMA     = 2;
    localparam int BUS_OWNER_DBG     = 3;
    typedef enum logic {ST_IDLE, ST_OWNED} arb_state_e;
endpackage

// File: rtl/yutorina_rr_picker.sv
// yutorina_rr_picker: first eligible requester scanning upward from a start pointer with wrap
module yutorina_rr_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    input  logic [N-1:0] i_excl,
    output logic         o_found,
    output logic [W-1:0] o_idx
);
    logic [N-1:0] w_elig;
    logic [W-1:0] w_idx [N];
    assign w_elig = i_req & ~i_excl;
    for (genvar j = 0; j < N; j++) begin : g_off
        logic [W:0] w_sum;
        assign w_sum = {1'b0, i_ptr} + (W+1)'(j);
        assign w_idx[j] = (w_sum >= (W+1)'(N)) ? W'(w_sum - (W+1)'(N)) : w_sum[W-1:0];
    end
    // scan from the far end so the closest eligible offset wins
    always_comb begin
        o_found = 1'b0;
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_elig[w_idx[i]]) begin
                o_found = 1'b1;
                o_idx = w_idx[i];
            end
        end
    end
endmodule

// File: rtl/yutorina_bus_arbiter.sv
// yutorina_bus_arbiter: round-robin external bus arbiter with hold watchdog
// Grants are registered, active-low, and held until release or watchdog preemption.
module yutorina_bus_arbiter
    import yutorina_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = BUS_MASTER_CNT,
    parameter int MAX_HOLD    = BUS_MAX_HOLD,
    parameter int OWNER_W     = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_,
    output logic [NUM_MASTERS-1:0] grnt_,
    output logic [OWNER_W-1:0]     owner,
    output logic                   owner_vld,
    output logic                   timeout,
    output logic [OWNER_W-1:0]     timeout_id
);
    localparam int HC_W = $clog2(MAX_HOLD + 1);
    localparam logic [OWNER_W-1:0] LAST = OWNER_W'(NUM_MASTERS - 1);
    localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);

    arb_state_e r_state, w_state;
    logic [NUM_MASTERS-1:0] r_grnt_, w_grnt_, w_req, w_owner_oh, w_others, w_excl;
    logic [OWNER_W-1:0] r_owner, w_owner, r_ptr, w_ptr, r_tid, w_tid;
    logic [OWNER_W-1:0] w_succ, w_pick_ptr, w_pick_idx;
    logic [HC_W-1:0] r_hold, w_hold;
    logic r_timeout, w_timeout, w_owned, w_rel, w_exp, w_found;

    assign w_req      = ~req_;
    assign w_owned    = r_state == ST_OWNED;
    assign w_owner_oh = NUM_MASTERS'(1) << r_owner;
    assign w_others   = w_req & ~w_owner_oh;
    assign w_succ     = (r_owner == LAST) ? '0 : r_owner + 1'b1;
    assign w_rel      = w_owned && !w_req[r_owner];
    // a release on the same edge as expiry wins because expiry needs the owner still requesting
    assign w_exp      = w_owned && w_req[r_owner] && r_hold == HOLD_MAX && |w_others;
    assign w_pick_ptr = w_owned ? w_succ : r_ptr;
    assign w_excl     = w_owned ? w_owner_oh : '0;

    yutorina_rr_picker #(.N(NUM_MASTERS), .W(OWNER_W)) u_picker (
        .i_req  (w_req),
        .i_ptr  (w_pick_ptr),
        .i_excl (w_excl),
        .o_found(w_found),
        .o_idx  (w_pick_idx)
    );

    always_comb begin
        w_state = r_state;
        w_owner = r_owner;
        w_ptr = r_ptr;
        w_tid = r_tid;
        w_hold = r_hold;
        w_timeout = 1'b0;
        if (!w_owned || w_rel || w_exp) begin
            w_state = w_found ? ST_OWNED : ST_IDLE;
            w_owner = w_found ? w_pick_idx : r_owner;
            w_ptr = w_pick_ptr;
            w_hold = '0;
            w_timeout = w_exp;
            w_tid = w_exp ? r_owner : r_tid;
        end else begin
            w_hold = !(|w_others) ? '0 : (r_hold == HOLD_MAX) ? r_hold : r_hold + 1'b1;
        end
        w_grnt_ = (w_state == ST_OWNED) ? ~(NUM_MASTERS'(1) << w_owner) : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr <= '0;
            r_tid <= '0;
            r_hold <= '0;
            r_timeout <= 1'b0;
            r_grnt_ <= '1;
        end else begin
            r_state <= w_state;
            r_owner <= w_owner;
            r_ptr <= w_ptr;
            r_tid <= w_tid;
            r_hold <= w_hold;
            r_timeout <= w_timeout;
            r_grnt_ <= w_grnt_;
        end
    end

    assign grnt_      = r_grnt_;
    assign owner      = r_owner;
    assign owner_vld  = w_owned;
    assign timeout    = r_timeout;
    assign timeout_id = r_tid;
endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// tb_yutorina_bus_arbiter: directed and random stimulus scored against a reference arbiter model
module tb_yutorina_bus_arbiter;
    localparam int N = 4;
    localparam int MH = 4;
    typedef struct {
        logic [3:0] grnt_;
        logic       vld;
        logic [1:0] owner;
        bit         chk_owner;
        logic       to;
        logic [1:0] tid;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] req_ = 4'hF;
    logic [3:0] grnt_;
    logic [1:0] owner, timeout_id;
    logic owner_vld, timeout;

    exp_t sb[$];
    exp_t me;
    int glog[$];
    int order[5] = '{0, 1, 2, 3, 0};
    int tests = 0, fails = 0;
    int m_own = -1, m_ptr = 0, m_hold = 0, m_tid = 0, m_age = 0;
    bit m_to = 1'b0;
    logic pv = 1'b0;
    logic [1:0] po = 2'd0;
    logic [3:0] rv;
    bit ok;

    always #5 clk = ~clk;

    yutorina_bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MH), .OWNER_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_      (req_),
        .grnt_     (grnt_),
        .owner     (owner),
        .owner_vld (owner_vld),
        .timeout   (timeout),
        .timeout_id(timeout_id)
    );

    function automatic int pick(logic [3:0] rq, int start, int excl);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (start + k) % N;
            if (rq[c] && c != excl) return c;
        end
        return -1;
    endfunction

    // drive one cycle of inputs and push the state the model expects after the next edge
    task automatic cyc(input logic [3:0] r, input logic rs);
        logic [3:0] rq;
        bit others;
        int prev;
        exp_t e;
        @(negedge clk);
        req_ = r;
        rst = rs;
        rq = ~r;
        prev = m_own;
        m_to = 1'b0;
        others = (m_own >= 0) && ((rq & ~(4'b1 << m_own)) != 4'b0);
        if (rs) begin
            m_own = -1; m_ptr = 0; m_hold = 0; m_tid = 0;
        end else if (m_own < 0) begin
            m_own = pick(rq, m_ptr, -1);
            m_hold = 0;
        end else if (!rq[m_own] || (m_hold == MH && others)) begin
            m_to = rq[m_own];
            if (m_to) m_tid = m_own;
            m_ptr = (m_own + 1) % N;
            m_own = pick(rq, m_ptr, m_own);
            m_hold = 0;
        end else begin
            m_hold = others ? ((m_hold < MH) ? m_hold + 1 : MH) : 0;
        end
        m_age = (m_own >= 0 && m_own == prev) ? m_age + 1 : 0;
        e.grnt_ = (m_own < 0) ? 4'hF : ~(4'b1 << m_own);
        e.vld = m_own >= 0;
        e.owner = rs ? 2'd0 : 2'(m_own);
        e.chk_owner = rs || m_own >= 0;
        e.to = m_to;
        e.tid = 2'(m_tid);
        sb.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                me = sb.pop_front();
                tests++;
                if (grnt_ !== me.grnt_ || owner_vld !== me.vld || timeout !== me.to ||
                    timeout_id !== me.tid || (me.chk_owner && owner !== me.owner)) begin
                    fails++;
                    $display("FAIL outputs t=%0t: got grnt_=%b vld=%b owner=%0d timeout=%b tid=%0d, want grnt_=%b vld=%b owner=%0d(chk=%0d) timeout=%b tid=%0d",
                             $time, grnt_, owner_vld, owner, timeout, timeout_id,
                             me.grnt_, me.vld, me.owner, me.chk_owner, me.to, me.tid);
                end
                tests++;
                if ($isunknown(grnt_) || $countones(~grnt_) > 1) begin
                    fails++;
                    $display("FAIL onehot t=%0t: got grnt_=%b, want at most one low bit", $time, grnt_);
                end
            end
            if (owner_vld === 1'b1 && (!pv || owner != po)) glog.push_back(int'(owner));
            pv = (owner_vld === 1'b1);
            po = owner;
        end
    end

    initial begin
        repeat (2) cyc(4'b0000, 1'b1);
        cyc(4'b0000, 1'b0);
        cyc(4'b0000, 1'b0);

        cyc(4'hF, 1'b1);
        glog.delete();
        repeat (20) begin
            rv = 4'b0000;
            if (m_own >= 0 && m_age >= 2) rv[m_own] = 1'b1;
            cyc(rv, 1'b0);
        end
        ok = glog.size() >= 5;
        for (int i = 0; i < 5; i++) if (ok && glog[i] != order[i]) ok = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rr_order: got %p, want 0,1,2,3,0 first", glog);
        end

        cyc(4'hF, 1'b1);
        repeat (3) cyc(4'b1101, 1'b0);
        repeat (8) cyc(4'b1001, 1'b0);

        cyc(4'hF, 1'b1);
        repeat (200) cyc(4'b0111, 1'b0);

        cyc(4'hF, 1'b1);
        cyc(4'b1110, 1'b0);
        repeat (4) cyc(4'b1100, 1'b0);
        repeat (3) cyc(4'b1101, 1'b0);

        cyc(4'hF, 1'b1);
        repeat (3) cyc(4'b1011, 1'b0);
        cyc(4'b1011, 1'b1);
        repeat (2) cyc(4'b0000, 1'b0);

        repeat (400) begin
            rv = 4'($urandom) & 4'($urandom);
            if (m_own >= 0) rv[m_own] = ($urandom_range(0, 7) == 0);
            cyc(rv, $urandom_range(0, 59) == 0);
        end

        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
